// File: rtl/kl8e_rx.sv
// KL8E console keyboard receiver: recovers 8N1 characters from rx for the KSF/KCC/KRS/KRB IOT logic.
// Build option RX_MAJORITY_EN: each bit decision is a 3-sample majority vote around the bit centre.
module kl8e_rx #(
  parameter int clock_frequency = 100_000_000,
  parameter int baud_rate       = 9600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        kbd_clr,
  output logic [4:11] rx_data,
  output logic        rx_flag,
  output logic        overrun,
  output logic        framing_err,
  output logic        busy
);

  localparam int BIT_PERIOD  = clock_frequency / baud_rate;
  localparam int HALF_PERIOD = BIT_PERIOD / 2;
  localparam int CNT_W       = $clog2(BIT_PERIOD);
`ifdef RX_MAJORITY_EN
  // The vote resolves one cycle after cnt reaches 0, so reload one shorter to keep the bit pitch.
  localparam int RELOAD = BIT_PERIOD - 2;
`else
  localparam int RELOAD = BIT_PERIOD - 1;
`endif
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(RELOAD);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q;
  logic             rx_meta_q, rxs_q, rxs_dly_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [4:11]      shreg_q;
  logic [4:11]      rx_data_q;
  logic             flag_q, ovr_q, fe_q, busy_q;
  logic             take;
  logic             sample;
`ifdef RX_MAJORITY_EN
  logic             vote_q, v1_q, v0_q;
`endif

  always_comb begin
    take   = 1'b0;
    sample = rxs_q;
`ifdef RX_MAJORITY_EN
    take   = vote_q;
    sample = (v1_q & v0_q) | (v1_q & rxs_q) | (v0_q & rxs_q);
`else
    take   = (state_q != IDLE) && (cnt_q == '0);
`endif
  end

  // NOTE: every register below uses <= so all of them update from the same pre-edge values;
  // later assignments in the block (e.g. the load in STOP) deliberately override earlier defaults.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      rxs_dly_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      rx_data_q <= '0;
      flag_q    <= 1'b0;
      ovr_q     <= 1'b0;
      fe_q      <= 1'b0;
      busy_q    <= 1'b0;
`ifdef RX_MAJORITY_EN
      vote_q    <= 1'b0;
      v1_q      <= 1'b1;
      v0_q      <= 1'b1;
`endif
    end else begin
      // NOTE: rx is asynchronous; two flops before any decision to contain metastability.
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
      rxs_dly_q <= rxs_q;

      if (kbd_clr) begin
        flag_q <= 1'b0;
        ovr_q  <= 1'b0;
      end

      if (state_q != IDLE && cnt_q != '0) cnt_q <= cnt_q - 1'b1;

`ifdef RX_MAJORITY_EN
      if (state_q != IDLE && !vote_q) begin
        if (cnt_q == CNT_W'(1)) v1_q <= rxs_q;
        if (cnt_q == '0) begin
          v0_q   <= rxs_q;
          vote_q <= 1'b1;
        end
      end
      if (take) vote_q <= 1'b0;
`endif

      case (state_q)
        IDLE: begin
          if (rxs_dly_q && !rxs_q) begin
            cnt_q   <= HALF_LOAD;
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (take) begin
            if (!sample) begin
              cnt_q     <= BIT_LOAD;
              bit_idx_q <= '0;
              state_q   <= DATA;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (take) begin
            shreg_q   <= {sample, shreg_q[4:10]};
            cnt_q     <= BIT_LOAD;
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) state_q <= STOP;
          end
        end
        STOP: begin
          if (take) begin
            // A coincident kbd_clr has already consumed the old flag, so it cannot overrun.
            rx_data_q <= shreg_q;
            fe_q      <= ~sample;
            ovr_q     <= ~kbd_clr & (ovr_q | flag_q);
            flag_q    <= 1'b1;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_flag     = flag_q;
  assign overrun     = ovr_q;
  assign framing_err = fe_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_kl8e_rx.sv
// Self-checking bench for kl8e_rx: 16-cycle bit period, scoreboard of expected loads.
module tb_kl8e_rx;

  localparam int BP = 16;
  localparam int NOMINAL_LAT = 155;
`ifdef RX_MAJORITY_EN
  localparam int LOAD_EDGE = 156;
  localparam bit MAJ = 1'b1;
`else
  localparam int LOAD_EDGE = 155;
  localparam bit MAJ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        kbd_clr = 1'b0;
  logic [4:11] rx_data;
  logic        rx_flag, overrun, framing_err, busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       flag;
    logic       ovr;
  } exp_t;

  exp_t sb[$];
  logic m_flag = 1'b0;
  logic m_ovr  = 1'b0;
  logic m_fe   = 1'b0;

  kl8e_rx #(.clock_frequency(160), .baud_rate(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .kbd_clr    (kbd_clr),
    .rx_data    (rx_data),
    .rx_flag    (rx_flag),
    .overrun    (overrun),
    .framing_err(framing_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one full 10-bit frame; rx is set just after edge i and seen by the DUT at edge i+1.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input int spike_at, input int clr_at);
    logic [9:0] bits;
    exp_t       e;
    int         lat;
    bit         busy_bad;
    logic       busy_prev;
    bits   = {stop_bit, data, 1'b0};
    e.data = data;
    if (!MAJ && spike_at >= 0) e.data = data | (8'h01 << (spike_at / BP - 1));
    e.fe   = ~stop_bit;
    e.ovr  = (clr_at == LOAD_EDGE - 1) ? 1'b0 : (m_ovr | m_flag);
    e.flag = 1'b1;
    sb.push_back(e);
    m_flag = 1'b1;
    m_ovr  = e.ovr;
    m_fe   = e.fe;
    lat       = -1;
    busy_bad  = 1'b0;
    busy_prev = busy;
    for (int i = 0; i < 10 * BP; i++) begin
      rx = bits[i / BP];
      if (i == spike_at) rx = 1'b1;
      kbd_clr = (i == clr_at);
      tick();
      if (busy_prev && !busy && lat < 0) lat = i + 1;
      if (i + 1 >= 4 && i + 1 <= 154 && !busy) busy_bad = 1'b1;
      busy_prev = busy;
    end
    kbd_clr = 1'b0;
    checks++;
    if (lat < NOMINAL_LAT - 1 || lat > NOMINAL_LAT + 1) begin
      errors++;
      $display("FAIL latency %h: got %0d expected %0d+-1", data, lat, NOMINAL_LAT);
    end
    checks++;
    if (busy_bad) begin
      errors++;
      $display("FAIL busy_frame %h: busy dropped during frame, expected high", data);
    end
  endtask

  task automatic check_load(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, expected a pending load", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (rx_data !== e.data) begin
      errors++;
      $display("FAIL %s rx_data: got %h expected %h", name, rx_data, e.data);
    end
    checks++;
    if (rx_flag !== e.flag) begin
      errors++;
      $display("FAIL %s rx_flag: got %b expected %b", name, rx_flag, e.flag);
    end
    checks++;
    if (overrun !== e.ovr) begin
      errors++;
      $display("FAIL %s overrun: got %b expected %b", name, overrun, e.ovr);
    end
    checks++;
    if (framing_err !== e.fe) begin
      errors++;
      $display("FAIL %s framing_err: got %b expected %b", name, framing_err, e.fe);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({rx_data, rx_flag, overrun, framing_err, busy} !== 12'h000) begin
      errors++;
      $display("FAIL %s: got data=%h flag=%b ovr=%b fe=%b busy=%b expected all 0",
               name, rx_data, rx_flag, overrun, framing_err, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check_all_zero("reset");
    repeat (5) tick();
  endtask

  task automatic test_false_start();
    bit saw_busy;
    saw_busy = 1'b0;
    rx = 1'b0;
    repeat (3) begin
      tick();
      if (busy) saw_busy = 1'b1;
    end
    rx = 1'b1;
    repeat (30) begin
      tick();
      if (busy) saw_busy = 1'b1;
    end
    checks++;
    if (!saw_busy) begin
      errors++;
      $display("FAIL false_start_detect: busy never rose, expected 1");
    end
    check_all_zero("false_start");
  endtask

  task automatic test_basic();
    rx = 1'b1;
    repeat (50) tick();
    send_frame(8'h41, 1'b1, -1, -1);
    check_load("basic_41");
  endtask

  task automatic test_back_to_back();
    send_frame(8'h55, 1'b1, -1, -1);
    check_load("overrun_55");
  endtask

  task automatic test_kbd_clr();
    rx = 1'b1;
    tick();
    kbd_clr = 1'b1;
    tick();
    kbd_clr = 1'b0;
    m_flag = 1'b0;
    m_ovr  = 1'b0;
    checks++;
    if ({rx_flag, overrun, framing_err} !== {m_flag, m_ovr, m_fe}) begin
      errors++;
      $display("FAIL kbd_clr: got flag/ovr/fe=%b%b%b expected %b%b%b",
               rx_flag, overrun, framing_err, m_flag, m_ovr, m_fe);
    end
    repeat (5) tick();
    send_frame(8'h0D, 1'b1, -1, LOAD_EDGE - 1);
    check_load("clr_at_load_0d");
  endtask

  task automatic test_framing();
    bit retrig;
    send_frame(8'h7F, 1'b0, -1, -1);
    check_load("framing_7f");
    retrig = 1'b0;
    rx = 1'b0;
    repeat (200) begin
      tick();
      if (busy) retrig = 1'b1;
    end
    checks++;
    if (retrig) begin
      errors++;
      $display("FAIL break_retrigger: busy rose during held-low line, expected 0");
    end
    rx = 1'b1;
    repeat (20) tick();
    send_frame(8'h20, 1'b1, -1, -1);
    check_load("after_break_20");
  endtask

  task automatic test_reset_mid();
    logic [9:0] bits;
    bits = {1'b1, 8'h33, 1'b0};
    for (int i = 0; i < 89; i++) begin
      rx = bits[i / BP];
      reset = (i == 88);
      tick();
    end
    reset = 1'b0;
    rx = 1'b1;
    m_flag = 1'b0;
    m_ovr  = 1'b0;
    m_fe   = 1'b0;
    check_all_zero("reset_mid_frame");
    repeat (30) tick();
    send_frame(8'h33, 1'b1, -1, -1);
    check_load("after_reset_33");
  endtask

  task automatic test_spike();
    rx = 1'b1;
    repeat (10) tick();
    send_frame(8'h00, 1'b1, 72, -1);
    check_load("spike_00");
  endtask

  initial begin
    test_reset();
    test_false_start();
    test_basic();
    test_back_to_back();
    test_kbd_clr();
    test_framing();
    test_reset_mid();
    test_spike();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
